// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, multi-cycle MULT/DIV sequencer, data-cache wait.
// Optional stalled-cycle counter is built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  RegAddrX_ID,
  input  logic [4:0]  RegAddrY_ID,
  input  logic [4:0]  RegAddr_EX,
  input  logic        MemRead_EX,
  input  logic        RegWrite_EX,
  input  logic        muldiv_start_EX,
  input  logic        branch_taken_ID,
  input  logic        dcache_stall,
  input  logic        perf_clr,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        stall_memwb,
  output logic        bubble_idex,
  output logic        bubble_exmem,
  output logic        flush_ifid,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic [15:0] stall_cycles
);

  typedef enum logic {RUN, MULB} state_t;

  localparam logic [15:0] LAT_M1 = 16'(MULDIV_LAT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        load_use;

  assign load_use = MemRead_EX && RegWrite_EX && (RegAddr_EX != 5'd0) &&
                    ((RegAddr_EX == RegAddrX_ID) || (RegAddr_EX == RegAddrY_ID));

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    stall_idex   = 1'b0;
    stall_exmem  = 1'b0;
    stall_memwb  = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    muldiv_done  = 1'b0;

    if (dcache_stall) begin
      // Memory wait freezes the whole pipe and the sequencer where they stand.
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      stall_memwb = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (muldiv_start_EX) begin
            state_d      = MULB;
            cnt_d        = LAT_M1;
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            bubble_exmem = 1'b1;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end
        end
        MULB: begin
          if (cnt_q == 16'd0) begin
            state_d     = RUN;
            muldiv_done = 1'b1;
          end else begin
            cnt_d        = cnt_q - 16'd1;
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            bubble_exmem = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign flush_ifid  = branch_taken_ID & ~stall_ifid;
  assign muldiv_busy = (state_q == MULB) | ((state_q == RUN) & muldiv_start_EX);

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (perf_clr)
      perf_d = '0;
    else if (stall_pc && (perf_q != 16'hFFFF))
      perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign stall_cycles = perf_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cycles    = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MULDIV_LAT=4): directed scenarios plus randomized traffic
// compared every cycle against an occupancy-based behavioural model.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  RegAddrX_ID, RegAddrY_ID, RegAddr_EX;
  logic        MemRead_EX, RegWrite_EX, muldiv_start_EX, branch_taken_ID, dcache_stall, perf_clr;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic        bubble_idex, bubble_exmem, flush_ifid, muldiv_busy, muldiv_done;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegAddrX_ID(RegAddrX_ID), .RegAddrY_ID(RegAddrY_ID), .RegAddr_EX(RegAddr_EX),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .muldiv_start_EX(muldiv_start_EX),
    .branch_taken_ID(branch_taken_ID), .dcache_stall(dcache_stall), .perf_clr(perf_clr),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem), .flush_ifid(flush_ifid),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done), .stall_cycles(stall_cycles)
  );

  int errors = 0;
  int checks = 0;

  // Model state: whether a MULT/DIV occupies EX, and how many EX cycles it has been served.
  bit m_mul    = 1'b0;
  int m_served = 0;
  int m_perf   = 0;

  logic [9:0] last_obs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
            bubble_idex, bubble_exmem, flush_ifid, muldiv_busy, muldiv_done};
  endfunction

  function automatic bit model_hit();
    return MemRead_EX && RegWrite_EX && RegAddr_EX != 0 &&
           (RegAddr_EX == RegAddrX_ID || RegAddr_EX == RegAddrY_ID);
  endfunction

  // Expected outputs, same bit order as obs_vec.
  function automatic logic [9:0] model_out();
    bit s_pc = 0, s_if = 0, s_id = 0, s_ex = 0, s_wb = 0, b_id = 0, b_ex = 0, done = 0;
    if (dcache_stall) begin
      {s_pc, s_if, s_id, s_ex, s_wb} = 5'b11111;
    end else if (!m_mul) begin
      if (muldiv_start_EX)  {s_pc, s_if, s_id, b_ex} = 4'b1111;
      else if (model_hit()) {s_pc, s_if, b_id} = 3'b111;
    end else if (m_served == LAT) begin
      done = 1;
    end else begin
      {s_pc, s_if, s_id, b_ex} = 4'b1111;
    end
    return {s_pc, s_if, s_id, s_ex, s_wb, b_id, b_ex,
            branch_taken_ID & ~s_if, m_mul | muldiv_start_EX, done};
  endfunction

  task automatic model_update();
    logic [9:0] e;
    e = model_out();
    if (!rst_n) begin
      m_mul = 0; m_served = 0; m_perf = 0;
      return;
    end
`ifdef HAZARD_PERF_CNT_EN
    if (perf_clr) m_perf = 0;
    else if (e[9] && m_perf < 16'hFFFF) m_perf++;
`endif
    if (!dcache_stall) begin
      if (!m_mul && muldiv_start_EX) begin
        m_mul = 1; m_served = 1;
      end else if (m_mul) begin
        if (m_served == LAT) m_mul = 0;
        else m_served++;
      end
    end
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    last_obs = obs_vec();
    check(tag, {22'd0, last_obs}, {22'd0, model_out()});
    check({tag, "_cnt"}, {16'd0, stall_cycles}, m_perf);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_in();
    RegAddrX_ID = 0; RegAddrY_ID = 0; RegAddr_EX = 0;
    MemRead_EX = 0; RegWrite_EX = 0; muldiv_start_EX = 0;
    branch_taken_ID = 0; dcache_stall = 0; perf_clr = 0;
  endtask

  initial begin
    int occ, done_at;
    idle_in();
    rst_n = 1'b0;
    #1;
    check("reset_outs", {22'd0, obs_vec()}, 32'd0);
    check("reset_cnt", {16'd0, stall_cycles}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Load-use: one stalled cycle with a bubble, then clear; r0 never interlocks.
    MemRead_EX = 1; RegWrite_EX = 1; RegAddr_EX = 5; RegAddrX_ID = 5;
    step("lu_hit");
    check("lu_hit_bits", {29'd0, last_obs[9], last_obs[8], last_obs[4]}, 32'b111);
    idle_in();
    step("lu_after");
    check("lu_after_pc", {31'd0, last_obs[9]}, 32'd0);
    MemRead_EX = 1; RegWrite_EX = 1; RegAddr_EX = 0; RegAddrX_ID = 0;
    step("lu_r0");
    check("lu_r0_pc", {31'd0, last_obs[9]}, 32'd0);

    // MULT held high: EX occupied LAT cycles, done right after the last stalled cycle.
    idle_in();
    muldiv_start_EX = 1;
    occ = 0; done_at = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      step("mul_seq");
      occ += int'(last_obs[7]);
      if (last_obs[0]) done_at = k;
    end
    muldiv_start_EX = 0;
    check("mul_occ", occ, LAT);
    check("mul_done_at", done_at, LAT + 1);
    step("mul_after");
    check("mul_after_busy", {31'd0, last_obs[1]}, 32'd0);

    // Three cycles of memory wait inside MULB stretch occupancy to LAT+3.
    muldiv_start_EX = 1;
    occ = 0; done_at = 0;
    for (int k = 1; k <= LAT + 4; k++) begin
      dcache_stall = (k >= 3 && k <= 5);
      step("mul_dc");
      occ += int'(last_obs[7]);
      if (last_obs[0]) done_at = k;
      if (k == 3) check("mul_dc_all", {27'd0, last_obs[9:5]}, 32'h1F);
    end
    idle_in();
    check("mul_dc_occ", occ, LAT + 3);
    check("mul_dc_done_at", done_at, LAT + 4);

    // Branch during a load-use stall is not flushed until the stall clears.
    MemRead_EX = 1; RegWrite_EX = 1; RegAddr_EX = 9; RegAddrY_ID = 9; branch_taken_ID = 1;
    step("br_stalled");
    check("br_stalled_flush", {31'd0, last_obs[2]}, 32'd0);
    MemRead_EX = 0;
    step("br_released");
    check("br_released_flush", {31'd0, last_obs[2]}, 32'd1);
    idle_in();

    // Reset in the second MULB cycle abandons the operation without a done pulse.
    muldiv_start_EX = 1;
    step("rst_mul0");
    muldiv_start_EX = 0;
    step("rst_mul1");
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, muldiv_busy}, 32'd0);
    check("rst_mid_done", {31'd0, muldiv_done}, 32'd0);
    check("rst_mid_idex", {31'd0, stall_idex}, 32'd0);
    m_mul = 0; m_served = 0; m_perf = 0;
    step("rst_hold");
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      step("rst_after");
      check("rst_after_done", {31'd0, last_obs[0]}, 32'd0);
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturation and clear of the stalled-cycle counter.
    dcache_stall = 1;
    repeat (70000) begin
      @(posedge clk);
      model_update();
      #1;
    end
    step("perf_sat");
    check("perf_sat_val", {16'd0, stall_cycles}, 32'hFFFF);
    perf_clr = 1;
    step("perf_clr");
    perf_clr = 0;
    step("perf_cleared");
    check("perf_cleared_val", {16'd0, stall_cycles}, 32'd0);
    idle_in();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      RegAddrX_ID     = 5'($urandom_range(0, 3));
      RegAddrY_ID     = 5'($urandom_range(0, 3));
      RegAddr_EX      = 5'($urandom_range(0, 3));
      MemRead_EX      = 1'($urandom_range(0, 1));
      RegWrite_EX     = 1'($urandom_range(0, 1));
      muldiv_start_EX = ($urandom_range(0, 9) == 0);
      dcache_stall    = ($urandom_range(0, 7) == 0);
      branch_taken_ID = 1'($urandom_range(0, 1));
      perf_clr        = ($urandom_range(0, 49) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
